digit_serial_adder: RTL and testbench

Parametrised, multi-cycle adder/subtractor that adds two WIDTH-bit operands DIGIT bits per clock, propagating the carry between cycles in a register. It is the area-reduced, generalised successor of the team's fixed 4-bit ripple-carry adder. It adds width and digit-size parameters, subtract mode, signed-overflow detection and a start/busy/done handshake. It sits as a slave arithmetic unit under a controller that issues one operation at a time.

---
 rtl/adder_pkg.sv | 7 +
 rtl/digit_adder.sv | 19 +
 rtl/fulladder.sv | 11 +
 rtl/digit_serial_adder.sv | 74 +++++++
 tb/tb_digit_serial_adder.sv | 153 +++++++++++++++
 5 files changed

// File: rtl/adder_pkg.sv
// adder_pkg: shared state encoding and counter-width helper for the digit-serial adder
package adder_pkg;
  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;
  function automatic int kw(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/digit_adder.sv
// digit_adder: DIGIT-wide ripple of full adders, also exposing the carry into the MSB
module digit_adder #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             ci,
  output logic [DIGIT-1:0] s,
  output logic             co,
  output logic             cm
);
  logic [DIGIT:0] c;
  assign c[0] = ci;
  for (genvar g = 0; g < DIGIT; g++) begin : g_fa
    fulladder u_fa (.a(a[g]), .b(b[g]), .ci(c[g]), .s(s[g]), .co(c[g+1]));
  end
  assign co = c[DIGIT];
  assign cm = c[DIGIT-1];
endmodule

// File: rtl/fulladder.sv
// fulladder: one-bit full adder cell
module fulladder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

// File: rtl/digit_serial_adder.sv
// digit_serial_adder: multi-cycle add/subtract, DIGIT bits per clock with a carry register
module digit_serial_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             cin,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int N  = WIDTH / DIGIT;
  localparam int KW = kw(N);
  state_t state, nxt;
  logic [KW-1:0] k;
  logic [WIDTH-1:0] xr, yr;
  logic cr;
  logic [DIGIT-1:0] xd, yd, ds;
  logic dco, dcm, last;
  assign last = k == KW'(N - 1);
  assign xd = DIGIT'(xr >> (DIGIT * k));
  assign yd = DIGIT'(yr >> (DIGIT * k));
  assign busy = state == RUN;
  digit_adder #(.DIGIT(DIGIT)) u_da (
    .a(xd), .b(yd), .ci(cr), .s(ds), .co(dco), .cm(dcm)
  );
  // next state: accept start when idle, leave RUN after the last digit
  always_comb nxt = state == IDLE ? (start ? RUN : IDLE) : (last ? IDLE : RUN);
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= nxt;
  // operand latch, digit counter, carry chain and result registers
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      k    <= '0;
      xr   <= '0;
      yr   <= '0;
      cr   <= 1'b0;
      sum  <= '0;
      cout <= 1'b0;
      ovf  <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        if (start) begin
          xr  <= x;
          yr  <= sub ? ~y : y;
          cr  <= cin ^ sub;
          k   <= '0;
          sum <= '0;
        end
      end else begin
        sum <= sum | (WIDTH'(ds) << (DIGIT * k));
        cr  <= dco;
        k   <= k + 1'b1;
        if (last) begin
          cout <= dco;
          ovf  <= dco ^ dcm;
          done <= 1'b1;
        end
      end
    end
endmodule

// File: tb/tb_digit_serial_adder.sv
// tb_digit_serial_adder: scoreboard bench with an arithmetic reference model
module tb_digit_serial_adder;
  typedef struct packed {
    logic [15:0] s;
    logic        c;
    logic        o;
  } exp_t;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, cin = 1'b0, sub = 1'b0;
  logic [15:0] x = '0, y = '0;
  logic busy, done, cout, ovf;
  logic [15:0] sum;
  int tests = 0, fails = 0;
  exp_t q[$];
  exp_t me;
  digit_serial_adder #(.WIDTH(16), .DIGIT(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .x(x), .y(y), .cin(cin), .sub(sub),
    .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf)
  );
  always #5 clk = ~clk;
  function automatic exp_t model(input logic [15:0] a, b, input logic c, s);
    int r, sr, sa, sb, ci;
    exp_t e;
    ci = c ? 1 : 0;
    sa = 32'($signed(a));
    sb = 32'($signed(b));
    if (!s) begin
      r   = int'(a) + int'(b) + ci;
      sr  = sa + sb + ci;
      e.c = r > 65535;
    end else begin
      r   = int'(a) - int'(b) - ci;
      sr  = sa - sb - ci;
      e.c = r >= 0;
    end
    e.s = 16'(r);
    e.o = sr > 32767 || sr < -32768;
    return e;
  endfunction
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", n, act, req);
    end
  endtask
  task automatic begin_op(input logic [15:0] a, b, input logic c, s, input bit keep);
    x = a;
    y = b;
    cin = c;
    sub = s;
    start = 1'b1;
    if (keep) q.push_back(model(a, b, c, s));
    @(posedge clk);
    #1 start = 1'b0;
  endtask
  task automatic wait_done(output int lat, output int bc);
    lat = 0;
    bc = 0;
    @(negedge clk);
    while (!done && lat < 20) begin
      bc += busy ? 1 : 0;
      @(negedge clk);
      lat++;
    end
    if (!done) chk("done_timeout", 0, 1);
  endtask
  // scoreboard monitor
  always @(negedge clk)
    if (rst_n && done) begin
      if (q.size() == 0) chk("spurious_done", 1, 0);
      else begin
        me = q.pop_front();
        chk("sum", 32'(sum), 32'(me.s));
        chk("cout", 32'(cout), 32'(me.c));
        chk("ovf", 32'(ovf), 32'(me.o));
      end
    end
  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end
  initial begin
    int lat, bc;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_sum", 32'(sum), 0);
    chk("rst_cout", 32'(cout), 0);
    chk("rst_ovf", 32'(ovf), 0);
    rst_n = 1'b1;
    @(negedge clk);
    begin_op(16'h1234, 16'h4321, 0, 0, 1);
    wait_done(lat, bc);
    chk("lat_first", 32'(lat), 4);
    chk("busy_cycles", 32'(bc), 4);
    chk("busy_at_done", 32'(busy), 0);
    @(negedge clk);
    chk("done_width", 32'(done), 0);
    begin_op(16'hFFFF, 16'h0001, 0, 0, 1);
    wait_done(lat, bc);
    begin_op(16'h7FFF, 16'h0001, 0, 0, 1);
    wait_done(lat, bc);
    begin_op(16'h0005, 16'h0007, 0, 1, 1);
    wait_done(lat, bc);
    begin_op(16'h0007, 16'h0005, 1, 1, 1);
    wait_done(lat, bc);
    begin_op(16'h0102, 16'h0304, 0, 0, 1);
    @(negedge clk);
    x = 16'hAAAA;
    y = 16'h5555;
    cin = 1'b1;
    sub = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(lat, bc);
    chk("lat_ignored_start", 32'(lat), 3);
    begin_op(16'h2222, 16'h1111, 0, 1, 1);
    chk("b2b_accepted", 32'(busy), 1);
    wait_done(lat, bc);
    chk("lat_b2b", 32'(lat), 4);
    begin_op(16'h8000, 16'h0001, 0, 1, 1);
    wait_done(lat, bc);
    @(negedge clk);
    begin_op(16'h1111, 16'h2222, 0, 0, 0);
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_busy", 32'(busy), 0);
    chk("arst_done", 32'(done), 0);
    chk("arst_sum", 32'(sum), 0);
    chk("arst_cout", 32'(cout), 0);
    chk("arst_ovf", 32'(ovf), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    chk("arst_idle", 32'(busy), 0);
    begin_op(16'h0001, 16'h0001, 0, 0, 1);
    wait_done(lat, bc);
    chk("lat_after_rst", 32'(lat), 4);
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
      begin_op(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1);
      wait_done(lat, bc);
      chk("lat_rand", 32'(lat), 4);
    end
    repeat (3) @(negedge clk);
    chk("queue_drained", 32'(q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
